icdf_fold_nch: RTL and testbench

Parametrised N-lane successor to the single-lane inverse-CDF fold stage: accepts NCH Sobol uniforms per beat in Q(QINT.QFRAC), folds each into the half-interval (0, 0.5] with a per-lane negate flag, and clamps away from zero so the downstream log/sqrt stage never sees 0. Adds range checking, a bypass mode, a tag side-channel and a 2-entry output FIFO so `ready_out` does not depend combinationally on `ready_in`. Sits between the Sobol generator and inverse-CDF step 2 in the path-generation pipeline.

---
 rtl/icdf_fold_nch_if.sv | 33 +++
 rtl/icdf_fold_nch.sv | 127 ++++++++++++
 tb/tb_icdf_fold_nch.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/icdf_fold_nch_if.sv
// Beat stream bundle for the N-lane inverse-CDF fold stage: upstream accept side
// (valid_in/ready_out/u/tag_in/fold_en) and downstream emit side
// (valid_out/ready_in/x/negate/clamped/range_err/tag_out).
interface icdf_fold_nch_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NCH   = 4,
  parameter int unsigned TAGW  = 8
) ();
  logic                  valid_in;
  logic                  ready_out;
  logic [NCH*WIDTH-1:0]  u;
  logic [TAGW-1:0]       tag_in;
  logic                  fold_en;
  logic                  valid_out;
  logic                  ready_in;
  logic [NCH*WIDTH-1:0]  x;
  logic [NCH-1:0]        negate;
  logic [NCH-1:0]        clamped;
  logic [NCH-1:0]        range_err;
  logic [TAGW-1:0]       tag_out;

  // Fold stage view
  modport slave (
    input  valid_in, u, tag_in, fold_en, ready_in,
    output ready_out, valid_out, x, negate, clamped, range_err, tag_out
  );

  // Producer/consumer view
  modport master (
    output valid_in, u, tag_in, fold_en, ready_in,
    input  ready_out, valid_out, x, negate, clamped, range_err, tag_out
  );
endinterface

// File: rtl/icdf_fold_nch.sv
// N-lane inverse-CDF fold stage. Folds each Q(QINT.QFRAC) uniform into (0, 0.5] with a
// negate flag, clamps away from zero, flags out-of-range lanes and buffers results in a
// 2-entry FIFO so ready_out is purely register-derived.
// Defaults mirror the platform fixed-point config (32-bit, Q16.16).
module icdf_fold_nch #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned QINT  = 16,
  parameter int unsigned QFRAC = 16,
  parameter int unsigned NCH   = 4,
  parameter int unsigned TAGW  = 8,
  parameter int unsigned EPS   = 1
) (
  input  logic                clk,
  input  logic                rst,
  icdf_fold_nch_if.slave      bus,
  input  logic                err_clr,
  output logic [15:0]         err_cnt
);

  localparam logic signed [WIDTH-1:0] One  = WIDTH'(64'd1 << QFRAC);
  localparam logic signed [WIDTH-1:0] Half = WIDTH'(64'd1 << (QFRAC - 1));
  localparam logic        [WIDTH-1:0] Eps  = WIDTH'(EPS);

  // Reject parameter sets where the Q format does not fit the lane
  if (QINT + QFRAC > WIDTH) begin : g_bad_qformat
    $error("QINT + QFRAC exceeds WIDTH");
  end
  if (EPS < 1 || EPS > (1 << (QFRAC - 1))) begin : g_bad_eps
    $error("EPS must lie in [1, HALF]");
  end

  typedef struct packed {
    logic [NCH*WIDTH-1:0] x;
    logic [NCH-1:0]       negate;
    logic [NCH-1:0]       clamped;
    logic [NCH-1:0]       range_err;
    logic [TAGW-1:0]      tag;
  } entry_t;

  entry_t     new_e;
  entry_t     head;
  entry_t     mem_q [2];
  logic       rd_ptr_q, wr_ptr_q;
  logic [1:0] count_q;
  logic [15:0] err_cnt_q;
  logic       push, pop;

  assign bus.ready_out = (count_q != 2'd2);
  assign bus.valid_out = (count_q != 2'd0);
  assign push = bus.valid_in && bus.ready_out;
  assign pop  = bus.valid_out && bus.ready_in;

  // Per-lane fold/clamp/range decode of the incoming beat
  always_comb begin
    logic signed [WIDTH-1:0] ui;
    logic        [WIDTH-1:0] xi;
    new_e     = '0;
    new_e.tag = bus.tag_in;
    for (int i = 0; i < int'(NCH); i++) begin
      ui = bus.u[i*WIDTH +: WIDTH];
      xi = ui;
      new_e.range_err[i] = (ui < 0) || (ui >= One);
      if (bus.fold_en) begin
        if (ui < 0) begin
          xi                = Eps;
          new_e.clamped[i]  = 1'b1;
        end else if (ui >= One) begin
          xi                = Eps;
          new_e.negate[i]   = 1'b1;
          new_e.clamped[i]  = 1'b1;
        end else if (ui <= Half) begin
          xi = ui;
        end else begin
          xi              = One - ui;
          new_e.negate[i] = 1'b1;
        end
        // Keep the downstream log/sqrt away from zero
        if (xi < Eps) begin
          xi               = Eps;
          new_e.clamped[i] = 1'b1;
        end
      end
      new_e.x[i*WIDTH +: WIDTH] = xi;
    end
  end

  // Two-entry ring buffer; reset drops every queued beat
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= new_e;
      wr_ptr_q <= wr_ptr_q ^ push;
      rd_ptr_q <= rd_ptr_q ^ pop;
      count_q  <= count_q + 2'(push) - 2'(pop);
    end
  end

  assign head          = mem_q[rd_ptr_q];
  assign bus.x         = head.x;
  assign bus.negate    = head.negate;
  assign bus.clamped   = head.clamped;
  assign bus.range_err = head.range_err;
  assign bus.tag_out   = head.tag;

  // Saturating count of accepted beats carrying any range error; clear has priority
  always_ff @(posedge clk) begin
    if (rst || err_clr) begin
      err_cnt_q <= 16'd0;
    end else if (push && (|new_e.range_err) && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_cnt = err_cnt_q;

  // A stalled beat must keep its payload until it is taken
  assert property (@(posedge clk) disable iff (rst)
    (bus.valid_in && !bus.ready_out) |=>
      (!bus.valid_in || ($stable(bus.u) && $stable(bus.tag_in) && $stable(bus.fold_en))))
    else $error("payload changed while stalled");

endmodule

// File: tb/tb_icdf_fold_nch.sv
// Directed bench for icdf_fold_nch: fold/clamp/range vectors, bypass, backpressure,
// full-rate streaming, error-counter saturation/clear and reset with a full FIFO.
module tb_icdf_fold_nch;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned QINT  = 16;
  localparam int unsigned QFRAC = 16;
  localparam int unsigned NCH   = 4;
  localparam int unsigned TAGW  = 8;
  localparam int unsigned EPS   = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        err_clr;
  logic [15:0] err_cnt;
  int          vecs  = 0;
  int          fails = 0;
  int          tp_n;
  int          exp_tag;
  logic        tp_ok;

  icdf_fold_nch_if #(.WIDTH(WIDTH), .NCH(NCH), .TAGW(TAGW)) bus ();

  icdf_fold_nch #(
    .WIDTH(WIDTH), .QINT(QINT), .QFRAC(QFRAC), .NCH(NCH), .TAGW(TAGW), .EPS(EPS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .err_clr (err_clr),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [127:0] uu, input logic [7:0] t, input logic fe);
    bus.u        = uu;
    bus.tag_in   = t;
    bus.fold_en  = fe;
    bus.valid_in = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.valid_in = 1'b0;
    bus.u        = '0;
    bus.tag_in   = '0;
    bus.fold_en  = 1'b1;
    bus.ready_in = 1'b1;
    err_clr      = 1'b0;
    rst          = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst_valid_out", 128'(bus.valid_out), 128'd0);
    chk("rst_ready_out", 128'(bus.ready_out), 128'd1);
    chk("rst_x", 128'(bus.x), 128'd0);
    chk("rst_flags", 128'({bus.negate, bus.clamped, bus.range_err}), 128'd0);
    chk("rst_tag", 128'(bus.tag_out), 128'd0);
    chk("rst_err_cnt", 128'(err_cnt), 128'd0);

    // Basic fold: lanes (0..3) = 0x4000, 0xC000, 0x8000, 0x0000
    drive({32'h0, 32'h8000, 32'hC000, 32'h4000}, 8'hA5, 1'b1);
    chk("v1_latency", 128'(bus.valid_out), 128'd0);
    step();
    bus.valid_in = 1'b0;
    chk("v1_valid", 128'(bus.valid_out), 128'd1);
    chk("v1_x", 128'(bus.x), {32'h1, 32'h8000, 32'h4000, 32'h4000});
    chk("v1_negate", 128'(bus.negate), 128'b0010);
    chk("v1_clamped", 128'(bus.clamped), 128'b1000);
    chk("v1_range_err", 128'(bus.range_err), 128'd0);
    chk("v1_tag", 128'(bus.tag_out), 128'hA5);
    step();
    chk("v1_drain", 128'(bus.valid_out), 128'd0);

    // Range and edge lanes: -1, ONE, ONE-1, 1
    drive({32'h1, 32'hFFFF, 32'h10000, 32'hFFFF_FFFF}, 8'h5A, 1'b1);
    step();
    bus.valid_in = 1'b0;
    chk("v2_x", 128'(bus.x), {32'h1, 32'h1, 32'h1, 32'h1});
    chk("v2_range_err", 128'(bus.range_err), 128'b0011);
    chk("v2_negate", 128'(bus.negate), 128'b0110);
    chk("v2_clamped", 128'(bus.clamped), 128'b0011);
    chk("v2_err_cnt", 128'(err_cnt), 128'd1);

    // Bypass, in-range lanes
    drive({32'h10, 32'h8001, 32'h0, 32'hC000}, 8'h33, 1'b0);
    step();
    bus.valid_in = 1'b0;
    chk("v3_x", 128'(bus.x), {32'h10, 32'h8001, 32'h0, 32'hC000});
    chk("v3_flags", 128'({bus.negate, bus.clamped, bus.range_err}), 128'd0);
    chk("v3_err_cnt", 128'(err_cnt), 128'd1);

    // Bypass with out-of-range lanes: no clamp, range_err still flagged
    drive({32'h1, 32'h8000, 32'h10000, 32'hFFFF_FFFF}, 8'h3B, 1'b0);
    step();
    bus.valid_in = 1'b0;
    chk("v4_x", 128'(bus.x), {32'h1, 32'h8000, 32'h10000, 32'hFFFF_FFFF});
    chk("v4_negate_clamped", 128'({bus.negate, bus.clamped}), 128'd0);
    chk("v4_range_err", 128'(bus.range_err), 128'b0011);
    chk("v4_err_cnt", 128'(err_cnt), 128'd2);
    step();

    // Backpressure: ready_in low for 5 edges while beats 1..4 are offered
    bus.ready_in = 1'b0;
    drive({4{32'h100}}, 8'd1, 1'b1);
    step();
    drive({4{32'h200}}, 8'd2, 1'b1);
    step();
    drive({4{32'h300}}, 8'd3, 1'b1);
    chk("bp_full_ready", 128'(bus.ready_out), 128'd0);
    chk("bp_full_valid", 128'(bus.valid_out), 128'd1);
    chk("bp_tag_c2", 128'(bus.tag_out), 128'd1);
    step();
    chk("bp_tag_c3", 128'(bus.tag_out), 128'd1);
    chk("bp_x_c3", 128'(bus.x), {4{32'h100}});
    step();
    step();
    chk("bp_tag_c5", 128'(bus.tag_out), 128'd1);
    chk("bp_x_c5", 128'(bus.x), {4{32'h100}});
    chk("bp_ready_c5", 128'(bus.ready_out), 128'd0);
    bus.ready_in = 1'b1;
    step();
    chk("bp_tag_c6", 128'(bus.tag_out), 128'd2);
    chk("bp_ready_c6", 128'(bus.ready_out), 128'd1);
    step();
    chk("bp_tag_c7", 128'(bus.tag_out), 128'd3);
    drive({4{32'h400}}, 8'd4, 1'b1);
    step();
    bus.valid_in = 1'b0;
    chk("bp_tag_c8", 128'(bus.tag_out), 128'd4);
    chk("bp_x_c8", 128'(bus.x), {4{32'h400}});
    step();
    chk("bp_empty", 128'(bus.valid_out), 128'd0);

    // Full rate: 100 beats over 101 edges, tags 0..99 in order
    tp_n    = 0;
    exp_tag = 0;
    tp_ok   = 1'b1;
    drive({4{32'h50}}, 8'd0, 1'b1);
    for (int c = 1; c <= 101; c++) begin
      step();
      if (c < 100) bus.tag_in = 8'(c);
      else         bus.valid_in = 1'b0;
      if (bus.valid_out) begin
        if (bus.tag_out !== 8'(exp_tag)) tp_ok = 1'b0;
        exp_tag++;
        tp_n++;
      end
    end
    chk("tp_count", 128'(tp_n), 128'd100);
    chk("tp_order", 128'(tp_ok), 128'd1);
    chk("tp_end", 128'(bus.valid_out), 128'd0);

    // Error counter: clear, saturate, clear beats a same-cycle increment
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("err_clr_idle", 128'(err_cnt), 128'd0);
    drive({96'h0, 32'hFFFF_FFFF}, 8'hEE, 1'b1);
    repeat (65534) step();
    chk("err_near_sat", 128'(err_cnt), 128'hFFFE);
    step();
    chk("err_sat", 128'(err_cnt), 128'hFFFF);
    step();
    chk("err_sat_hold", 128'(err_cnt), 128'hFFFF);
    err_clr = 1'b1;
    step();
    err_clr      = 1'b0;
    bus.valid_in = 1'b0;
    chk("err_clr_wins", 128'(err_cnt), 128'd0);
    step();

    // Reset with the FIFO full
    bus.ready_in = 1'b0;
    drive({4{32'h100}}, 8'h77, 1'b1);
    step();
    step();
    bus.valid_in = 1'b0;
    chk("rf_full", 128'(bus.ready_out), 128'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rf_valid_out", 128'(bus.valid_out), 128'd0);
    chk("rf_ready_out", 128'(bus.ready_out), 128'd1);
    chk("rf_tag", 128'(bus.tag_out), 128'd0);
    bus.ready_in = 1'b1;
    step();
    chk("rf_no_ghost", 128'(bus.valid_out), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
